// File: rtl/shift_add_mult4_pkg.sv
// shift_add_mult4_pkg: state encodings and iteration count for the shift-add multiplier
package shift_add_mult4_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  localparam int ITER = 4;
endpackage

// File: rtl/shift_add_mult4_add.sv
// add: 4-bit ripple-carry adder shared with the lab datapath
module add (
  input  logic       C_in,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] S,
  output logic       C4
);
  logic [4:0] c;
  assign c[0] = C_in;
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end
  assign C4 = c[4];
endmodule

// File: rtl/shift_add_mult4.sv
// shift_add_mult4: sequential 4x4 unsigned shift-and-add multiplier, one partial product per clock
module shift_add_mult4
  import shift_add_mult4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);
  state_t     state;
  logic [3:0] m, acc, q, s;
  logic [1:0] cnt;
  logic       c4;
  add u_add (
    .C_in(1'b0),
    .A   (acc),
    .B   (q[0] ? m : 4'h0),
    .S   (s),
    .C4  (c4)
  );
  assign busy = state != ST_IDLE;
  assign done = state == ST_DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          m     <= a;
          q     <= b;
          acc   <= '0;
          cnt   <= '0;
          state <= ST_CALC;
        end
        ST_CALC: begin
          // carry out lands in acc[3]; the shifted-out multiplier bit is consumed
          {acc, q} <= {c4, s, q[3:1]};
          cnt      <= cnt + 2'd1;
          if (cnt == 2'(ITER - 1)) begin
            product <= {c4, s, q[3:1]};
            state   <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_add_mult4.sv
// tb_shift_add_mult4: directed table plus corner sequences and an exhaustive sweep
module tb_shift_add_mult4;
  logic       clk = 0, rst_n = 0, start = 0;
  logic [3:0] a_i = 0, b_i = 0;
  logic       busy, done;
  logic [7:0] product;
  int         checks = 0, errors = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
    logic       noise;
  } vec_t;
  vec_t tv[4];

  shift_add_mult4 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a_i), .b(b_i),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // one operation: start for one cycle, optional start/operand noise while busy
  task automatic op(input logic [3:0] av, input logic [3:0] bv, input logic [7:0] exp,
                    input logic noise, input string nm);
    int n;
    @(negedge clk);
    a_i = av; b_i = bv; start = 1;
    @(negedge clk);
    start = 0;
    chk({nm, " busy_after_E0"}, 8'(busy), 8'd1);
    n = 0;
    while (!done && n < 20) begin
      if (noise) begin start = 1; a_i = ~a_i; b_i = b_i + 4'd5; end
      @(negedge clk);
      n++;
      if (!done && n < 20 && !busy) n = 20;
    end
    chk({nm, " latency"}, 8'(n), 8'd4);
    chk({nm, " busy_in_done"}, 8'(busy), 8'd1);
    chk({nm, " product"}, product, exp);
    @(negedge clk);
    start = 0;
    chk({nm, " done_width"}, 8'(done), 8'd0);
    chk({nm, " idle_after"}, 8'(busy), 8'd0);
    chk({nm, " product_hold"}, product, exp);
  endtask

  initial begin
    int n;
    tv[0] = '{4'h0, 4'h0, 8'h00, 1'b0};
    tv[1] = '{4'hF, 4'hF, 8'hE1, 1'b0};
    tv[2] = '{4'hA, 4'h3, 8'h1E, 1'b1};
    tv[3] = '{4'h1, 4'h8, 8'h08, 1'b1};

    #12;
    chk("reset product", product, 8'h00);
    chk("reset busy", 8'(busy), 8'd0);
    chk("reset done", 8'(done), 8'd0);
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    chk("idle no start", 8'(busy), 8'd0);

    for (int i = 0; i < 4; i++) op(tv[i].a, tv[i].b, tv[i].p, tv[i].noise, $sformatf("vec%0d", i));

    // back-to-back: start held from the done cycle is taken as soon as the FSM is idle
    op(4'hA, 4'h3, 8'h1E, 1'b0, "pre_b2b");
    @(negedge clk);
    a_i = 4'h7; b_i = 4'h9; start = 1;
    @(negedge clk);
    start = 0;
    a_i = 4'h0; b_i = 4'h0;
    n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    chk("b2b latency", 8'(n), 8'd4);
    chk("b2b product", product, 8'h3F);
    n = 0;
    @(negedge clk);
    a_i = 4'h2; b_i = 4'h3; start = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    start = 0;
    chk("b2b held start product", product, 8'h06);
    chk("b2b held start bounded", 8'(n < 20), 8'd1);
    @(negedge clk);

    // async reset mid-CALC
    @(negedge clk);
    a_i = 4'hF; b_i = 4'hF; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst mid product", product, 8'h00);
    chk("rst mid busy", 8'(busy), 8'd0);
    chk("rst mid done", 8'(done), 8'd0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("post rst idle", 8'(busy), 8'd0);
    chk("post rst product", product, 8'h00);

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        op(4'(x), 4'(y), 8'(x * y), 1'b0, $sformatf("ex_%0d_%0d", x, y));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
